// File: rtl/dsp_pkg.sv
// Shared DSP-bus sizing and operand/result types, used by the MAC array
// and by the convolution controller that drives it.
package dsp_pkg;

    localparam int DSP_LANES = 5;
    localparam int DSP_A_W   = 18;
    localparam int DSP_B_W   = 18;
    localparam int DSP_P_W   = 37;

    typedef logic [DSP_A_W-1:0] dsp_a_t;
    typedef logic [DSP_B_W-1:0] dsp_b_t;
    typedef logic [DSP_P_W-1:0] dsp_p_t;

endpackage

// File: rtl/dsp_lane.sv
// One multiply(-accumulate) lane: operand stage, product stages and the result
// register, all advancing together on ce and zeroed by clr or reset.
(* use_dsp = "yes" *)
module dsp_lane
    import dsp_pkg::*;
#(
    parameter int A_W    = DSP_A_W,
    parameter int B_W    = DSP_B_W,
    parameter int P_W    = DSP_P_W,
    parameter int PIPE   = 3,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           clr,
    input  logic           acc_in,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    output logic [P_W-1:0] p_out
);

    logic [P_W-1:0] fin_prod;
    logic           fin_acc;
    logic [P_W-1:0] out_q, out_d;

    function automatic logic [P_W-1:0] ext_a(input logic [A_W-1:0] v);
        logic signed [A_W-1:0] vs;
        vs = v;
        if (SIGNED != 0) return P_W'(vs);
        else             return P_W'(v);
    endfunction

    function automatic logic [P_W-1:0] ext_b(input logic [B_W-1:0] v);
        logic signed [B_W-1:0] vs;
        vs = v;
        if (SIGNED != 0) return P_W'(vs);
        else             return P_W'(v);
    endfunction

    // Operands widened to P_W first, so the truncated product is exact in both modes.
    function automatic logic [P_W-1:0] mul_ext(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
        return ext_a(x) * ext_b(y);
    endfunction

    function automatic logic [P_W-1:0] acc_wrap(input logic acc, input logic [P_W-1:0] sum,
                                                input logic [P_W-1:0] prod);
        return acc ? sum + prod : prod;
    endfunction

    if (PIPE == 1) begin : g_comb
        assign fin_prod = mul_ext(a_in, b_in);
        assign fin_acc  = acc_in;
    end else begin : g_reg
        logic [A_W-1:0] a_p1_q, a_p1_d;
        logic [B_W-1:0] b_p1_q, b_p1_d;
        logic           acc_p1_q, acc_p1_d;

        // stage 1: operand capture
        always_comb begin
            a_p1_d   = a_p1_q;
            b_p1_d   = b_p1_q;
            acc_p1_d = acc_p1_q;
            if (clr) begin
                a_p1_d   = '0;
                b_p1_d   = '0;
                acc_p1_d = 1'b0;
            end else if (ce) begin
                a_p1_d   = a_in;
                b_p1_d   = b_in;
                acc_p1_d = acc_in;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_p1_q   <= '0;
                b_p1_q   <= '0;
                acc_p1_q <= 1'b0;
            end else begin
                a_p1_q   <= a_p1_d;
                b_p1_q   <= b_p1_d;
                acc_p1_q <= acc_p1_d;
            end
        end

        if (PIPE == 2) begin : g_direct
            assign fin_prod = mul_ext(a_p1_q, b_p1_q);
            assign fin_acc  = acc_p1_q;
        end else begin : g_prod
            logic [P_W-1:0]  prod_pn_q [2:PIPE-1];
            logic [P_W-1:0]  prod_pn_d [2:PIPE-1];
            logic [PIPE-1:2] acc_pn_q, acc_pn_d;

            // stages 2..PIPE-1: product delay line with its acc flag
            always_comb begin
                prod_pn_d = prod_pn_q;
                acc_pn_d  = acc_pn_q;
                if (clr) begin
                    for (int s = 2; s < PIPE; s++) prod_pn_d[s] = '0;
                    acc_pn_d = '0;
                end else if (ce) begin
                    prod_pn_d[2] = mul_ext(a_p1_q, b_p1_q);
                    acc_pn_d[2]  = acc_p1_q;
                    for (int s = 3; s < PIPE; s++) begin
                        prod_pn_d[s] = prod_pn_q[s-1];
                        acc_pn_d[s]  = acc_pn_q[s-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_pn_q <= '{default: '0};
                    acc_pn_q  <= '0;
                end else begin
                    prod_pn_q <= prod_pn_d;
                    acc_pn_q  <= acc_pn_d;
                end
            end

            assign fin_prod = prod_pn_q[PIPE-1];
            assign fin_acc  = acc_pn_q[PIPE-1];
        end
    end

    // final stage: result register, accumulating on its own previous value
    always_comb begin
        out_d = out_q;
        if (clr)     out_d = '0;
        else if (ce) out_d = acc_wrap(fin_acc, out_q, fin_prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign p_out = out_q;

endmodule

// File: rtl/dsp_mac_array.sv
// Bank of independent MAC lanes on the DSP bus; owns the single valid pipe
// shared by all lanes, since every lane advances on the same ce.
module dsp_mac_array
    import dsp_pkg::*;
#(
    parameter int LANES  = DSP_LANES,
    parameter int A_W    = DSP_A_W,
    parameter int B_W    = DSP_B_W,
    parameter int P_W    = DSP_P_W,
    parameter int PIPE   = 3,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] dsp_a0 [0:LANES-1],
    input  logic [B_W-1:0] dsp_b0 [0:LANES-1],
    input  logic           dsp_ce,
    input  logic           dsp_acc,
    input  logic           dsp_clr,
    output logic [P_W-1:0] dsp_out [0:LANES-1],
    output logic           dsp_valid
);

    logic [PIPE-1:0] vld_q, vld_d;

    // A 1 enters per ce edge; the top bit marks dsp_out as holding a real sample.
    always_comb begin
        vld_d = vld_q;
        if (dsp_clr)     vld_d = '0;
        else if (dsp_ce) vld_d = (vld_q << 1) | PIPE'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign dsp_valid = vld_q[PIPE-1];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dsp_lane #(
            .A_W    (A_W),
            .B_W    (B_W),
            .P_W    (P_W),
            .PIPE   (PIPE),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .ce     (dsp_ce),
            .clr    (dsp_clr),
            .acc_in (dsp_acc),
            .a_in   (dsp_a0[l]),
            .b_in   (dsp_b0[l]),
            .p_out  (dsp_out[l])
        );
    end

endmodule

// File: tb/tb_dsp_mac_array.sv
// Bench for dsp_mac_array: unsigned and signed arrays driven side by side,
// checked each cycle against a sample-queue model plus hand-computed values.
module tb_dsp_mac_array;
    import dsp_pkg::*;

    localparam int PIPE = 3;

    logic   clk = 1'b0;
    logic   rst_n;
    dsp_a_t a_in [0:DSP_LANES-1];
    dsp_b_t b_in [0:DSP_LANES-1];
    logic   ce, acc, clr;
    dsp_p_t u_out [0:DSP_LANES-1];
    dsp_p_t s_out [0:DSP_LANES-1];
    logic   u_valid, s_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dsp_mac_array #(.LANES(DSP_LANES), .A_W(DSP_A_W), .B_W(DSP_B_W), .P_W(DSP_P_W),
                    .PIPE(PIPE), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .dsp_a0(a_in), .dsp_b0(b_in), .dsp_ce(ce),
        .dsp_acc(acc), .dsp_clr(clr), .dsp_out(u_out), .dsp_valid(u_valid));

    dsp_mac_array #(.LANES(DSP_LANES), .A_W(DSP_A_W), .B_W(DSP_B_W), .P_W(DSP_P_W),
                    .PIPE(PIPE), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .dsp_a0(a_in), .dsp_b0(b_in), .dsp_ce(ce),
        .dsp_acc(acc), .dsp_clr(clr), .dsp_out(s_out), .dsp_valid(s_valid));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each ce edge enters a sample; the sample that entered PIPE-1 edges earlier
    // lands in dsp_out (overwrite or add). After reset/clear the pipe behaves as
    // if filled with zero samples carrying acc=0.
    typedef struct packed {
        logic                              acc;
        logic [DSP_LANES-1:0][DSP_A_W-1:0] a;
        logic [DSP_LANES-1:0][DSP_B_W-1:0] b;
    } smp_t;

    smp_t   mq [$];
    dsp_p_t m_u [0:DSP_LANES-1];
    dsp_p_t m_s [0:DSP_LANES-1];
    int     ce_cnt;
    logic   m_valid;

    function automatic dsp_p_t model_mul(input dsp_a_t x, input dsp_b_t y, input bit sgn);
        longint xs, ys;
        if (sgn) begin
            xs = longint'($signed(x));
            ys = longint'($signed(y));
        end else begin
            xs = longint'(x);
            ys = longint'(y);
        end
        return DSP_P_W'(xs * ys);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < PIPE - 1; i++) mq.push_back('0);
        for (int l = 0; l < DSP_LANES; l++) begin
            m_u[l] = '0;
            m_s[l] = '0;
        end
        ce_cnt = 0;
    endtask

    initial begin
        smp_t s, h;
        dsp_p_t pu, ps;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clr) begin
                model_reset();
            end else if (ce) begin
                s.acc = acc;
                for (int l = 0; l < DSP_LANES; l++) begin
                    s.a[l] = a_in[l];
                    s.b[l] = b_in[l];
                end
                mq.push_back(s);
                h = mq.pop_front();
                for (int l = 0; l < DSP_LANES; l++) begin
                    pu = model_mul(h.a[l], h.b[l], 1'b0);
                    ps = model_mul(h.a[l], h.b[l], 1'b1);
                    m_u[l] = h.acc ? m_u[l] + pu : pu;
                    m_s[l] = h.acc ? m_s[l] + ps : ps;
                end
                if (ce_cnt < PIPE) ce_cnt++;
            end
        end
    end

    assign m_valid = (ce_cnt >= PIPE);

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int l = 0; l < DSP_LANES; l++) begin
                chk($sformatf("u_out%0d", l), 64'(u_out[l]), 64'(m_u[l]));
                chk($sformatf("s_out%0d", l), 64'(s_out[l]), 64'(m_s[l]));
            end
            chk("u_valid", 64'(u_valid), 64'(m_valid));
            chk("s_valid", 64'(s_valid), 64'(m_valid));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        acc   = 1'b0;
        clr   = 1'b0;
        for (int l = 0; l < DSP_LANES; l++) begin
            a_in[l] = '0;
            b_in[l] = '0;
        end
        repeat (3) tick();
        chk("rst_out0", 64'(u_out[0]), 64'd0);
        chk("rst_vld", 64'(u_valid), 64'd0);

        // first result after PIPE ce edges
        rst_n   = 1'b1;
        a_in[0] = 18'd200;
        b_in[0] = 18'd100;
        ce      = 1'b1;
        for (int e = 1; e < PIPE; e++) begin
            tick();
            chk("fill_out0", 64'(u_out[0]), 64'd0);
            chk("fill_vld", 64'(u_valid), 64'd0);
        end
        tick();
        chk("first_out0", 64'(u_out[0]), 64'd20000);
        chk("first_vld", 64'(u_valid), 64'd1);

        // freeze with ce low
        a_in[0] = 18'd7;
        b_in[0] = 18'd9;
        tick();
        ce      = 1'b0;
        a_in[0] = '0;
        b_in[0] = '0;
        repeat (5) begin
            tick();
            chk("frz_out0", 64'(u_out[0]), 64'd20000);
            chk("frz_vld", 64'(u_valid), 64'd1);
        end
        ce = 1'b1;
        tick();
        chk("thaw1_out0", 64'(u_out[0]), 64'd20000);
        tick();
        chk("thaw2_out0", 64'(u_out[0]), 64'd63);

        // accumulate chain on lane 2
        a_in[2] = 18'd3; b_in[2] = 18'd4;  acc = 1'b0; tick();
        a_in[2] = 18'd5; b_in[2] = 18'd6;  acc = 1'b1; tick();
        a_in[2] = 18'd2; b_in[2] = 18'd10; acc = 1'b1; tick();
        chk("acc1_out2", 64'(u_out[2]), 64'd12);
        a_in[2] = '0; b_in[2] = '0; acc = 1'b0; tick();
        chk("acc2_out2", 64'(u_out[2]), 64'd42);
        tick();
        chk("acc3_out2", 64'(u_out[2]), 64'd62);

        // full-width product and modulo wrap on lane 1
        a_in[1] = 18'h3FFFF; b_in[1] = 18'h3FFFF; acc = 1'b0; tick();
        acc = 1'b1; tick();
        tick();
        chk("wide_u_out1", 64'(u_out[1]), 64'h0FFFF80001);
        chk("wide_s_out1", 64'(s_out[1]), 64'd1);
        a_in[1] = '0; b_in[1] = '0; acc = 1'b0; tick();
        chk("wide2_u_out1", 64'(u_out[1]), 64'h1FFFF00002);
        chk("wide2_s_out1", 64'(s_out[1]), 64'd2);
        tick();
        chk("wrap_u_out1", 64'(u_out[1]), 64'h0FFFE80003);
        chk("wrap_s_out1", 64'(s_out[1]), 64'd3);

        // signed product on lane 3
        a_in[3] = 18'h3FFFD; b_in[3] = 18'd5; tick();
        a_in[3] = '0; b_in[3] = '0; tick();
        tick();
        chk("sgn_s_out3", 64'(s_out[3]), 64'h1FFFFFFFF1);
        chk("sgn_u_out3", 64'(u_out[3]), 64'h13FFF1);

        // clear with ce, two samples in flight on lane 4
        a_in[4] = 18'd11; b_in[4] = 18'd13; tick();
        a_in[4] = 18'd2;  b_in[4] = 18'd3;  tick();
        a_in[4] = 18'd9;  b_in[4] = 18'd9;  clr = 1'b1; tick();
        chk("clr_out4", 64'(u_out[4]), 64'd0);
        chk("clr_vld", 64'(u_valid), 64'd0);
        clr = 1'b0;
        a_in[4] = 18'd4; b_in[4] = 18'd5; tick();
        chk("clr_f1_vld", 64'(u_valid), 64'd0);
        a_in[4] = '0; b_in[4] = '0; tick();
        chk("clr_f2_vld", 64'(u_valid), 64'd0);
        chk("clr_f2_out4", 64'(u_out[4]), 64'd0);
        tick();
        chk("clr_res_out4", 64'(u_out[4]), 64'd20);
        chk("clr_res_vld", 64'(u_valid), 64'd1);

        // clear with ce low still clears
        ce = 1'b0; clr = 1'b1; tick();
        chk("clr_noce_out4", 64'(u_out[4]), 64'd0);
        chk("clr_noce_vld", 64'(u_valid), 64'd0);
        clr = 1'b0; ce = 1'b1;

        // asynchronous reset between edges
        a_in[4] = 18'd6; b_in[4] = 18'd7; tick();
        a_in[4] = '0; b_in[4] = '0; tick();
        tick();
        chk("pre_arst_out4", 64'(u_out[4]), 64'd42);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out4", 64'(u_out[4]), 64'd0);
        chk("arst_s_out4", 64'(s_out[4]), 64'd0);
        chk("arst_vld", 64'(u_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_in[4] = 18'd1; b_in[4] = 18'd1;
        tick();
        tick();
        chk("post_arst2_vld", 64'(u_valid), 64'd0);
        tick();
        chk("post_arst3_out4", 64'(u_out[4]), 64'd1);
        chk("post_arst3_vld", 64'(u_valid), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
